sram_arbiter: RTL and testbench

Two-master arbiter sharing one single-ported `sram` memory channel between the instruction-fetch bus and the data bus of the NaiveMIPS core. The block registers arbitration, latches the winning request, and drives the downstream `sram.master` port until the memory drops `stall`. It routes `data_r` and per-port `stall` back to the winners. The data bus has priority; a starvation counter guarantees fetch progress.

---
 rtl/sram_arbiter_pkg.sv | 8 +
 rtl/sram_if.sv | 14 +
 rtl/sram_arb_pick.sv | 17 +
 rtl/sram_arbiter.sv | 85 ++++++++
 tb/tb_sram_arbiter.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared bus widths and arbiter state encoding.
//   W_ADDR, W_DATA : sram channel address/data widths
//   arb_state_t    : arbiter grant state
package sram_arbiter_pkg;
    localparam int W_ADDR = 32;
    localparam int W_DATA = 32;
    typedef enum logic [1:0] {ARB_IDLE, ARB_IBUS, ARB_DBUS} arb_state_t;
endpackage

// File: rtl/sram_if.sv
// sram: single-ported memory channel.
//   master drives en/we/addr/data_w, slave returns data_r/stall.
//   A transfer completes in the cycle with en=1 and stall=0.
interface sram;
    import sram_arbiter_pkg::*;
    logic              en;
    logic [3:0]        we;
    logic [W_ADDR-1:0] addr;
    logic [W_DATA-1:0] data_w;
    logic [W_DATA-1:0] data_r;
    logic              stall;
    modport master (output en, we, addr, data_w, input data_r, stall);
    modport slave  (input en, we, addr, data_w, output data_r, stall);
endinterface

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational grant picker, dbus priority with starvation override.
//   ibus_en, dbus_en : pending requests
//   starve_cnt       : consecutive dbus picks while ibus waited
//   grant_i, grant_d : one-hot (or zero) pick result
module sram_arb_pick #(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          ibus_en,
    input  logic          dbus_en,
    input  logic [CW-1:0] starve_cnt,
    output logic          grant_i,
    output logic          grant_d
);
    assign grant_d = dbus_en & ~(ibus_en & (starve_cnt == CW'(STARVE_LIMIT)));
    assign grant_i = ibus_en & ~grant_d;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram channel between instruction-fetch and data buses.
//   clk, rst : clock, synchronous active-high reset
//   ibus     : fetch requester (read-only, write enables ignored)
//   dbus     : load/store requester, wins unless ibus has starved
//   mem      : downstream memory, driven from the request latch
//   busy     : high while a grant is outstanding
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    sram.slave   ibus,
    sram.slave   dbus,
    sram.master  mem,
    output logic busy
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state, state_next;
    logic [CW-1:0]     starve_cnt;
    logic              req_en;
    logic [3:0]        req_we;
    logic [W_ADDR-1:0] req_addr;
    logic [W_DATA-1:0] req_data;
    logic              grant_i, grant_d;

    sram_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT), .CW(CW)) pick (
        .ibus_en    (ibus.en),
        .dbus_en    (dbus.en),
        .starve_cnt (starve_cnt),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_comb begin
        state_next = (state == ARB_IDLE) ? (grant_d ? ARB_DBUS : grant_i ? ARB_IBUS : ARB_IDLE)
                                         : (mem.stall ? state : ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        state <= rst ? ARB_IDLE : state_next;
    end

    // req_en mirrors "state != ARB_IDLE" but lives in its own flop so mem.en is flop-driven
    always_ff @(posedge clk) begin
        if (rst) begin
            req_en     <= 1'b0;
            req_we     <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            starve_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            req_en <= grant_i | grant_d;
            if (grant_d) begin
                req_addr <= dbus.addr;
                req_we   <= dbus.we;
                req_data <= dbus.data_w;
            end else if (grant_i) begin
                req_addr <= ibus.addr;
                req_we   <= '0;
                req_data <= ibus.data_w;
            end
            if (grant_d & ibus.en)
                starve_cnt <= (starve_cnt == CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
            else if (grant_i | grant_d)
                starve_cnt <= '0;
        end else if (!mem.stall) begin
            req_en <= 1'b0;
        end
    end

    assign mem.en     = req_en;
    assign mem.we     = req_we;
    assign mem.addr   = req_addr;
    assign mem.data_w = req_data;
    assign busy       = req_en;

    // a requester that dropped en sees stall=0 and its late response is simply ignored
    assign ibus.stall  = ibus.en & ~(state == ARB_IBUS & ~mem.stall);
    assign dbus.stall  = dbus.en & ~(state == ARB_DBUS & ~mem.stall);
    assign ibus.data_r = (state == ARB_IBUS) ? mem.data_r : '0;
    assign dbus.data_r = (state == ARB_DBUS) ? mem.data_r : '0;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   vecs = 0;
    int   errs = 0;
    int   wait_cfg = 0;
    int   wcnt = 0;

    sram ibus();
    sram dbus();
    sram mem();

    sram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .ibus (ibus.slave),
        .dbus (dbus.slave),
        .mem  (mem.master),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // memory model: wait_cfg stall cycles per transfer, data_r = addr ^ K
    always_ff @(posedge clk) wcnt <= (rst || !(mem.en && mem.stall)) ? 0 : wcnt + 1;
    assign mem.stall  = mem.en && (wcnt < wait_cfg);
    assign mem.data_r = mem.en ? (mem.addr ^ K) : '0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ibus.en = 0; ibus.we = 0; ibus.addr = 0; ibus.data_w = 0;
        dbus.en = 0; dbus.we = 0; dbus.addr = 0; dbus.data_w = 0;
    endtask

    task automatic test_reset();
        rst = 1; ibus.en = 1;
        cyc(); cyc();
        vecs++; if (dut.state !== ARB_IDLE) begin errs++; $display("FAIL reset_state got %0d want %0d", dut.state, ARB_IDLE); end
        vecs++; if (mem.en !== 1'b0) begin errs++; $display("FAIL reset_mem_en got %b want 0", mem.en); end
        vecs++; if (mem.we !== 4'b0000) begin errs++; $display("FAIL reset_mem_we got %b want 0000", mem.we); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (dut.starve_cnt !== 3'd0) begin errs++; $display("FAIL reset_starve got %0d want 0", dut.starve_cnt); end
        vecs++; if (ibus.stall !== 1'b1) begin errs++; $display("FAIL reset_ibus_stall got %b want 1", ibus.stall); end
        vecs++; if (dbus.stall !== 1'b0) begin errs++; $display("FAIL reset_dbus_stall got %b want 0", dbus.stall); end
        rst = 0; ibus.en = 0;
        cyc();
    endtask

    task automatic test_single_ibus();
        wait_cfg = 0;
        ibus.en = 1; ibus.addr = 32'h1FC0_0000; ibus.we = 4'b0011;
        #1;
        vecs++; if (ibus.stall !== 1'b1) begin errs++; $display("FAIL single_stall_n got %b want 1", ibus.stall); end
        cyc();
        vecs++; if (mem.en !== 1'b1) begin errs++; $display("FAIL single_mem_en got %b want 1", mem.en); end
        vecs++; if (mem.addr !== 32'h1FC0_0000) begin errs++; $display("FAIL single_mem_addr got %h want 1fc00000", mem.addr); end
        vecs++; if (mem.we !== 4'b0000) begin errs++; $display("FAIL single_mem_we got %b want 0000", mem.we); end
        vecs++; if (ibus.stall !== 1'b0) begin errs++; $display("FAIL single_stall_n1 got %b want 0", ibus.stall); end
        vecs++; if (ibus.data_r !== (32'h1FC0_0000 ^ K)) begin errs++; $display("FAIL single_data_r got %h want %h", ibus.data_r, 32'h1FC0_0000 ^ K); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy got %b want 1", busy); end
        idle_inputs();
        cyc();
        vecs++; if (dut.state !== ARB_IDLE) begin errs++; $display("FAIL single_idle got %0d want %0d", dut.state, ARB_IDLE); end
        vecs++; if (mem.en !== 1'b0) begin errs++; $display("FAIL single_mem_en_n2 got %b want 0", mem.en); end
    endtask

    task automatic test_simultaneous();
        wait_cfg = 2;
        ibus.en = 1; ibus.addr = 32'h1FC0_0010; ibus.we = 4'b0011;
        dbus.en = 1; dbus.addr = 32'h0000_0100; dbus.we = 4'b1111; dbus.data_w = 32'hDEAD_BEEF;
        cyc();
        vecs++; if (dut.state !== ARB_DBUS) begin errs++; $display("FAIL sim_first_grant got %0d want %0d", dut.state, ARB_DBUS); end
        vecs++; if (mem.we !== 4'b1111) begin errs++; $display("FAIL sim_dbus_we got %b want 1111", mem.we); end
        vecs++; if (mem.data_w !== 32'hDEAD_BEEF) begin errs++; $display("FAIL sim_dbus_data_w got %h want deadbeef", mem.data_w); end
        vecs++; if (dbus.stall !== 1'b1) begin errs++; $display("FAIL sim_dbus_stall_n1 got %b want 1", dbus.stall); end
        cyc(); cyc();
        vecs++; if (dbus.stall !== 1'b0) begin errs++; $display("FAIL sim_dbus_done_n3 got %b want 0", dbus.stall); end
        vecs++; if (dbus.data_r !== (32'h0000_0100 ^ K)) begin errs++; $display("FAIL sim_dbus_data_r got %h want %h", dbus.data_r, 32'h0000_0100 ^ K); end
        vecs++; if (ibus.stall !== 1'b1) begin errs++; $display("FAIL sim_ibus_loser_stall got %b want 1", ibus.stall); end
        vecs++; if (ibus.data_r !== 32'h0) begin errs++; $display("FAIL sim_ibus_data_r_zero got %h want 0", ibus.data_r); end
        dbus.en = 0;
        cyc();
        vecs++; if (dut.state !== ARB_IDLE) begin errs++; $display("FAIL sim_turnaround got %0d want %0d", dut.state, ARB_IDLE); end
        vecs++; if (dut.starve_cnt !== 3'd1) begin errs++; $display("FAIL sim_starve_n4 got %0d want 1", dut.starve_cnt); end
        cyc();
        vecs++; if (dut.state !== ARB_IBUS) begin errs++; $display("FAIL sim_second_grant got %0d want %0d", dut.state, ARB_IBUS); end
        vecs++; if (mem.we !== 4'b0000) begin errs++; $display("FAIL sim_ibus_we_forced got %b want 0000", mem.we); end
        vecs++; if (mem.addr !== 32'h1FC0_0010) begin errs++; $display("FAIL sim_ibus_addr got %h want 1fc00010", mem.addr); end
        vecs++; if (dut.starve_cnt !== 3'd0) begin errs++; $display("FAIL sim_starve_clear got %0d want 0", dut.starve_cnt); end
        cyc(); cyc();
        vecs++; if (ibus.stall !== 1'b0) begin errs++; $display("FAIL sim_ibus_done got %b want 0", ibus.stall); end
        vecs++; if (ibus.data_r !== (32'h1FC0_0010 ^ K)) begin errs++; $display("FAIL sim_ibus_data_r got %h want %h", ibus.data_r, 32'h1FC0_0010 ^ K); end
        idle_inputs();
        cyc();
    endtask

    task automatic test_starvation();
        arb_state_t exp_grant [5] = '{ARB_DBUS, ARB_DBUS, ARB_DBUS, ARB_DBUS, ARB_IBUS};
        logic [2:0] exp_cnt [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        wait_cfg = 0;
        ibus.en = 1; ibus.addr = 32'h1FC0_0020;
        dbus.en = 1; dbus.addr = 32'h0000_0200;
        for (int k = 0; k < 5; k++) begin
            #1;
            vecs++; if (dut.starve_cnt !== exp_cnt[k]) begin errs++; $display("FAIL starve_cnt_%0d got %0d want %0d", k, dut.starve_cnt, exp_cnt[k]); end
            cyc();
            vecs++; if (dut.state !== exp_grant[k]) begin errs++; $display("FAIL starve_grant_%0d got %0d want %0d", k, dut.state, exp_grant[k]); end
            if (k == 4) begin
                vecs++; if (dut.starve_cnt !== 3'd0) begin errs++; $display("FAIL starve_after_ibus got %0d want 0", dut.starve_cnt); end
                idle_inputs();
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        wait_cfg = 10;
        ibus.en = 1; dbus.en = 1; dbus.addr = 32'h0000_0300;
        cyc(); cyc();
        vecs++; if (dut.state !== ARB_DBUS) begin errs++; $display("FAIL rmid_pre_state got %0d want %0d", dut.state, ARB_DBUS); end
        vecs++; if (dut.starve_cnt !== 3'd1) begin errs++; $display("FAIL rmid_pre_starve got %0d want 1", dut.starve_cnt); end
        rst = 1;
        cyc();
        vecs++; if (dut.state !== ARB_IDLE) begin errs++; $display("FAIL rmid_state got %0d want %0d", dut.state, ARB_IDLE); end
        vecs++; if (mem.en !== 1'b0) begin errs++; $display("FAIL rmid_mem_en got %b want 0", mem.en); end
        vecs++; if (dut.starve_cnt !== 3'd0) begin errs++; $display("FAIL rmid_starve got %0d want 0", dut.starve_cnt); end
        vecs++; if (dbus.stall !== 1'b1) begin errs++; $display("FAIL rmid_dbus_stall got %b want 1", dbus.stall); end
        rst = 0;
        idle_inputs();
        cyc();
    endtask

    task automatic test_drop_en();
        wait_cfg = 3;
        dbus.en = 1; dbus.addr = 32'h2000_0040;
        cyc();
        vecs++; if (mem.addr !== 32'h2000_0040) begin errs++; $display("FAIL drop_addr_n1 got %h want 20000040", mem.addr); end
        dbus.en = 0; dbus.addr = 32'h0;
        #1;
        vecs++; if (dbus.stall !== 1'b0) begin errs++; $display("FAIL drop_stall got %b want 0", dbus.stall); end
        cyc();
        vecs++; if (mem.addr !== 32'h2000_0040) begin errs++; $display("FAIL drop_addr_latched got %h want 20000040", mem.addr); end
        vecs++; if (mem.en !== 1'b1) begin errs++; $display("FAIL drop_mem_en_held got %b want 1", mem.en); end
        cyc(); cyc();
        vecs++; if (mem.stall !== 1'b0 || mem.en !== 1'b1) begin errs++; $display("FAIL drop_complete got en=%b stall=%b want en=1 stall=0", mem.en, mem.stall); end
        cyc();
        vecs++; if (dut.state !== ARB_IDLE) begin errs++; $display("FAIL drop_idle got %0d want %0d", dut.state, ARB_IDLE); end
        cyc();
        vecs++; if (mem.en !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL drop_no_spurious got en=%b busy=%b want 0 0", mem.en, busy); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_ibus();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_drop_en();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
